// File: rtl/rns_reverse_converter_pipe.sv
// Three-stage pipelined reverse converter for the RNS moduli set {2^N+1, 2^N, 2^N-1}.
// Produces X = {Y, x2}, where Y is assembled modulo 2^(2N)-1 from three rotated operands.
module rns_reverse_converter_pipe #(
    parameter int N     = 6,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N:0]         x1,
    input  logic [N-1:0]       x2,
    input  logic [N-1:0]       x3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*N-1:0]     out,
    output logic               out_err,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int W = 2 * N;
    localparam logic [N:0]   M1_VAL = {1'b1, {(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   TWO_N  = {1'b1, {N{1'b0}}};
    localparam logic [N-1:0] ONES_N = '1;

    // Modulo 2^W-1 addition; a single end-around carry can never overflow again.
    function automatic logic [W-1:0] eac_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0] + W'(s[W]);
    endfunction

    logic           s1_valid, s2_valid;
    logic [W-1:0]   s1_a, s1_b, s1_c;
    logic [N-1:0]   s1_x2, s2_x2;
    logic           s1_err, s2_err;
    logic [W-1:0]   s2_ab, s2_c;

    logic           adv1, adv2, adv3;
    logic           accept;

    logic [N:0]     x1_red;
    logic [N-1:0]   q;
    logic [W-1:0]   op_a0, op_a, op_b, op_c0, op_c;
    logic           in_bad;
    logic [W-1:0]   y_sum, y_val;

    always_comb begin
        adv3     = ~out_valid | out_ready;
        adv2     = ~s2_valid | adv3;
        adv1     = ~s1_valid | adv2;
        in_ready = adv1 & ~rst;
        accept   = in_valid & in_ready;
    end

    // Operand for x1 is 2^(N-1)*(2^N-1)*r with r = -x1 mod (2^N+1); (2^N-1)*r packs as {r-1, ~(r-1)}.
    always_comb begin
        x1_red = (x1 > TWO_N) ? (x1 - M1_VAL) : x1;
        q      = -x1_red[N-1:0];
        op_a0  = (x1_red == '0) ? '0 : {q, ~q};
        op_a   = {op_a0[N:0], op_a0[W-1:N+1]};
        op_b   = {~x2, ONES_N};
        op_c0  = {x3, x3};
        op_c   = {op_c0[N:0], op_c0[W-1:N+1]};
        in_bad = (x1 > TWO_N) || (x3 == ONES_N);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_x2    <= '0;
            s1_err   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= op_a;
                s1_b   <= op_b;
                s1_c   <= op_c;
                s1_x2  <= x2;
                s1_err <= in_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_ab    <= '0;
            s2_c     <= '0;
            s2_x2    <= '0;
            s2_err   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ab  <= eac_add(s1_a, s1_b);
                s2_c   <= s1_c;
                s2_x2  <= s1_x2;
                s2_err <= s1_err;
            end
        end
    end

    // All-ones is the redundant encoding of zero modulo 2^W-1.
    always_comb begin
        y_sum = eac_add(s2_ab, s2_c);
        y_val = (y_sum == '1) ? '0 : y_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
        end else if (adv3) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out     <= {y_val, s2_x2};
                out_err <= s2_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && in_bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// Self-checking bench for rns_reverse_converter_pipe (N=6): directed cases, random streams with
// backpressure, error saturation and mid-flight reset, against a CRT search reference model.
module tb_rns_reverse_converter_pipe;

    localparam int N     = 6;
    localparam int ERR_W = 8;
    localparam int W1    = N + 1;
    localparam int M1    = 65;
    localparam int M2    = 64;
    localparam int M3    = 63;
    localparam int MY    = 4095;
    localparam int M     = 262080;
    localparam int SAT   = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N:0]       x1;
    logic [N-1:0]     x2;
    logic [N-1:0]     x3;
    logic             out_valid;
    logic             out_ready;
    logic [3*N-1:0]   out;
    logic             out_err;
    logic [ERR_W-1:0] err_cnt;

    int      checks = 0;
    int      errors = 0;
    longint  exp_q[$];
    int      pop_cycles[$];
    int      cyc = 0;
    int      ready_mode = 1;
    int      model_err = 0;
    int      stall_cycles = 0;

    always #5 clk = ~clk;

    rns_reverse_converter_pipe #(.N(N), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: find the unique Y in [0, 2^12-1) satisfying both congruences by search.
    function automatic longint refConvert(input int a, input int b, input int c);
        int x1r, x3r, t1, t3;
        x1r = a % M1;
        x3r = (c == M3) ? 0 : c;
        t1  = ((b - x1r) % M1 + M1) % M1;
        t3  = ((x3r - (b % M3)) % M3 + M3) % M3;
        for (int y = 0; y < MY; y++) begin
            if ((y % M1 == t1) && (y % M3 == t3))
                return longint'(b) + longint'(M2) * longint'(y);
        end
        return -1;
    endfunction

    task automatic applyStimulusExp(input int a, input int b, input int c,
                                    input longint exp_x, input bit exp_bad, input bit rand_gap);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        while (!done && tries < 2000) begin
            @(negedge clk);
            #1;
            tries++;
            if (rand_gap && ($urandom % 2 == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                x1 = W1'(a);
                x2 = N'(b);
                x3 = N'(c);
                #1;
                if (in_ready) begin
                    done = 1'b1;
                    exp_q.push_back((longint'(exp_bad) << (3 * N)) | exp_x);
                    if (exp_bad && model_err < SAT) model_err++;
                end else if (!rand_gap) begin
                    stall_cycles++;
                end
            end
        end
        if (!done) checkOutput("accept_timeout", 64'(tries), 64'd0);
    endtask

    task automatic applyStimulus(input int a, input int b, input int c, input bit rand_gap);
        bit bad;
        bad = (a > M2) || (c == M3);
        applyStimulusExp(a, b, c, refConvert(a, b, c), bad, rand_gap);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Output-side monitor: drives out_ready, checks hold-while-stalled and scoreboard order.
    initial begin
        bit          prev_stall;
        logic [63:0] held;
        prev_stall = 1'b0;
        held       = '0;
        out_ready  = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
                out_ready  = (ready_mode != 0);
            end else begin
                if (prev_stall)
                    checkOutput("stall_hold", 64'({out_valid, out_err, out}),
                                (64'd1 << (3 * N + 1)) | held);
                if (ready_mode == 2) out_ready = 1'($urandom % 2);
                else                 out_ready = (ready_mode == 1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        checkOutput("unexpected_output", 64'({out_err, out}), '1);
                    else
                        checkOutput("result", 64'({out_err, out}), 64'(exp_q.pop_front()));
                    pop_cycles.push_back(cyc);
                end
                prev_stall = out_valid && !out_ready;
                held       = 64'({out_err, out});
            end
        end
    end

    initial begin
        int base;
        int xv, a, b;
        rst        = 1'b1;
        in_valid   = 1'b0;
        x1         = '0;
        x2         = '0;
        x3         = '0;
        ready_mode = 1;

        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out", 64'(out), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);

        @(negedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("in_ready_after_rst", 64'(in_ready), 64'd1);

        $display("[TB] latency check with zero triple");
        applyStimulusExp(0, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1 in_valid = 1'b0;
        #1 checkOutput("latency_edge1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #2 checkOutput("latency_edge2", 64'(out_valid), 64'd0);
        @(posedge clk);
        #2 checkOutput("latency_edge3", 64'(out_valid), 64'd1);

        $display("[TB] directed conversions");
        applyStimulusExp(30, 32, 19, 100000, 1'b0, 1'b0);
        applyStimulusExp(64, 0, 1, 64, 1'b0, 1'b0);
        applyStimulusExp(64, 63, 62, 262079, 1'b0, 1'b0);
        idle();
        waitDrain();

        $display("[TB] back-to-back stream of 1000 values");
        base = pop_cycles.size();
        stall_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            xv = int'($urandom_range(M - 1, 0));
            applyStimulusExp(xv % M1, xv % M2, xv % M3, longint'(xv), 1'b0, 1'b0);
        end
        idle();
        waitDrain();
        checkOutput("stream_stalls", 64'(stall_cycles), 64'd0);
        if (pop_cycles.size() >= base + 1000)
            checkOutput("stream_rate", 64'(pop_cycles[base + 999] - pop_cycles[base]), 64'd999);
        else
            checkOutput("stream_count", 64'(pop_cycles.size() - base), 64'd1000);

        $display("[TB] random backpressure with mixed residues");
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(int'($urandom_range(127, 0)), int'($urandom_range(63, 0)),
                          int'($urandom_range(63, 0)), 1'b1);
        end
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(64, 0));
            b = int'($urandom_range(63, 0));
            applyStimulus(a, b, M3, 1'b1);
        end
        idle();
        waitDrain();
        checkOutput("err_cnt_saturated", 64'(err_cnt), 64'(model_err));

        $display("[TB] reset with three triples in flight");
        ready_mode = 0;
        applyStimulus(10, 20, 30, 1'b0);
        applyStimulus(70, 5, 63, 1'b0);
        applyStimulus(1, 2, 3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 checkOutput("inflight_out_valid", 64'(out_valid), 64'd1);
        rst       = 1'b1;
        in_valid  = 1'b0;
        exp_q.delete();
        model_err = 0;
        @(negedge clk);
        #2;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_err_cnt", 64'(err_cnt), 64'(model_err));
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        ready_mode = 1;
        base = pop_cycles.size();
        repeat (10) @(negedge clk);
        #2;
        checkOutput("no_stale_pops", 64'(pop_cycles.size() - base), 64'd0);
        checkOutput("no_stale_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
